// File: rtl/div_ctrl.sv
// Divide controller for the EX stage.
// Accepts a signed/unsigned divide request from the pipeline and starts the
// external divider. While the divider works it stalls the pipeline. It then
// captures the remainder/quotient and pulses the HI/LO write enable once.
// The DRAIN state adds a one-cycle start=0 gap so the divider can return to
// its free state before the next operation is accepted.
module div_ctrl #(
   parameter logic [7:0] DIV_OP  = 8'b00011010,
   parameter logic [7:0] DIVU_OP = 8'b00011011
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic        flush_i,
   input  logic        div_ready_i,
   input  logic [63:0] div_result_i,
   output logic        div_start_o,
   output logic        div_annul_o,
   output logic        signed_div_o,
   output logic [31:0] div_opdata1_o,
   output logic [31:0] div_opdata2_o,
   output logic        stallreq_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_BUSY  = 2'b01,
      ST_DRAIN = 2'b10
   } state_e;

   state_e      state_q, state_d;
   logic        start_q, start_d;
   logic        signed_q, signed_d;
   logic [31:0] op1_q, op1_d;
   logic [31:0] op2_q, op2_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        is_div_s;
   logic        is_divu_s;
   logic        req_s;
   logic        stall_s;
   logic        annul_s;
   logic        whilo_s;

   // A request is any divide opcode that is not being flushed this cycle.
   always_comb begin
      is_div_s  = (aluop_i == DIV_OP);
      is_divu_s = (aluop_i == DIVU_OP);
      req_s     = (is_div_s | is_divu_s) & ~flush_i;
   end

   // Next-state and combinational outputs of the controller FSM.
   always_comb begin
      state_d  = state_q;
      start_d  = start_q;
      signed_d = signed_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      stall_s  = 1'b0;
      annul_s  = 1'b0;
      whilo_s  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            stall_s = req_s;
            if (req_s) begin
               op1_d    = reg1_i;
               op2_d    = reg2_i;
               signed_d = is_div_s;
               start_d  = 1'b1;
               state_d  = ST_BUSY;
            end else begin
               state_d  = ST_IDLE;
            end
         end

         ST_BUSY: begin
            stall_s = 1'b1;
            // A flush wins over a result arriving in the same cycle.
            if (flush_i) begin
               annul_s = 1'b1;
               start_d = 1'b0;
               state_d = ST_IDLE;
            end else if (div_ready_i) begin
               hi_d    = div_result_i[63:32];
               lo_d    = div_result_i[31:0];
               start_d = 1'b0;
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_BUSY;
            end
         end

         ST_DRAIN: begin
            // The result is already captured; a flush here only kills the write.
            whilo_s = ~flush_i;
            state_d = ST_IDLE;
         end

         default: begin
            start_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs, cleared asynchronously by the reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         start_q  <= 1'b0;
         signed_q <= 1'b0;
         op1_q    <= 32'd0;
         op2_q    <= 32'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         signed_q <= signed_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign div_start_o   = start_q;
   assign signed_div_o  = signed_q;
   assign div_opdata1_o = op1_q;
   assign div_opdata2_o = op2_q;
   assign hi_o          = hi_q;
   assign lo_o          = lo_q;
   assign stallreq_o    = stall_s;
   assign div_annul_o   = annul_s;
   assign whilo_o       = whilo_s;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl. The divider is modelled by
// driving div_ready_i/div_result_i with hand-computed results.
module tb_div_ctrl;

   localparam logic [7:0] DIV_OP  = 8'b00011010;
   localparam logic [7:0] DIVU_OP = 8'b00011011;
   localparam logic [7:0] NOP_OP  = 8'b00000000;

   logic        clk;
   logic        rst;
   logic [7:0]  aluop_i;
   logic [31:0] reg1_i;
   logic [31:0] reg2_i;
   logic        flush_i;
   logic        div_ready_i;
   logic [63:0] div_result_i;
   logic        div_start_o;
   logic        div_annul_o;
   logic        signed_div_o;
   logic [31:0] div_opdata1_o;
   logic [31:0] div_opdata2_o;
   logic        stallreq_o;
   logic        whilo_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int vectors;
   int errors;

   div_ctrl #(.DIV_OP(DIV_OP), .DIVU_OP(DIVU_OP)) dut (
      .clk          (clk),
      .rst          (rst),
      .aluop_i      (aluop_i),
      .reg1_i       (reg1_i),
      .reg2_i       (reg2_i),
      .flush_i      (flush_i),
      .div_ready_i  (div_ready_i),
      .div_result_i (div_result_i),
      .div_start_o  (div_start_o),
      .div_annul_o  (div_annul_o),
      .signed_div_o (signed_div_o),
      .div_opdata1_o(div_opdata1_o),
      .div_opdata2_o(div_opdata2_o),
      .stallreq_o   (stallreq_o),
      .whilo_o      (whilo_o),
      .hi_o         (hi_o),
      .lo_o         (lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      aluop_i = NOP_OP; reg1_i = 32'hDEAD_BEEF; reg2_i = 32'h1234_5678;
      flush_i = 1'b0; div_ready_i = 1'b0; div_result_i = 64'd0;
      cyc();
      vectors++; if (div_start_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", div_start_o); end
      vectors++; if (signed_div_o !== 1'b0) begin errors++; $display("FAIL reset_signed: got %b want 0", signed_div_o); end
      vectors++; if (div_opdata1_o !== 32'd0 || div_opdata2_o !== 32'd0) begin errors++; $display("FAIL reset_ops: got %h/%h want 0/0", div_opdata1_o, div_opdata2_o); end
      vectors++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin errors++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi_o, lo_o); end
      vectors++; if ({stallreq_o, div_annul_o, whilo_o} !== 3'b000) begin errors++; $display("FAIL reset_comb: got %b want 000", {stallreq_o, div_annul_o, whilo_o}); end
      // A request during reset shows on stallreq but must not start anything.
      aluop_i = DIV_OP;
      #1;
      vectors++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL reset_req_stall: got %b want 1", stallreq_o); end
      cyc();
      vectors++; if (div_start_o !== 1'b0 || div_opdata1_o !== 32'd0) begin errors++; $display("FAIL reset_req_nostart: got start=%b op1=%h want 0/0", div_start_o, div_opdata1_o); end
      aluop_i = NOP_OP;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_signed();
      cyc();
      aluop_i = DIV_OP; reg1_i = 32'hFFFF_FFF9; reg2_i = 32'd2;
      @(negedge clk);
      vectors++; if (stallreq_o !== 1'b1 || div_start_o !== 1'b0) begin errors++; $display("FAIL sdiv_accept: got stall=%b start=%b want 1/0", stallreq_o, div_start_o); end
      // Three busy cycles with the operands changing underneath.
      for (int i = 0; i < 3; i++) begin
         cyc();
         reg1_i = 32'h0000_0100 + i; reg2_i = 32'h0000_0200 + i;
         @(negedge clk);
         vectors++; if (div_start_o !== 1'b1 || stallreq_o !== 1'b1 || signed_div_o !== 1'b1) begin errors++; $display("FAIL sdiv_busy%0d: got start=%b stall=%b signed=%b want 111", i, div_start_o, stallreq_o, signed_div_o); end
         vectors++; if (div_opdata1_o !== 32'hFFFF_FFF9 || div_opdata2_o !== 32'd2) begin errors++; $display("FAIL sdiv_hold%0d: got %h/%h want fffffff9/2", i, div_opdata1_o, div_opdata2_o); end
         vectors++; if (div_annul_o !== 1'b0 || whilo_o !== 1'b0) begin errors++; $display("FAIL sdiv_busy_quiet%0d: got annul=%b whilo=%b want 00", i, div_annul_o, whilo_o); end
      end
      cyc();
      div_ready_i = 1'b1; div_result_i = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
      @(negedge clk);
      vectors++; if (stallreq_o !== 1'b1 || whilo_o !== 1'b0) begin errors++; $display("FAIL sdiv_ready: got stall=%b whilo=%b want 1/0", stallreq_o, whilo_o); end
      cyc();
      div_ready_i = 1'b0; div_result_i = 64'hAAAA_AAAA_5555_5555; aluop_i = NOP_OP;
      @(negedge clk);
      vectors++; if (whilo_o !== 1'b1 || stallreq_o !== 1'b0 || div_start_o !== 1'b0) begin errors++; $display("FAIL sdiv_drain: got whilo=%b stall=%b start=%b want 1/0/0", whilo_o, stallreq_o, div_start_o); end
      vectors++; if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_result: got %h/%h want ffffffff/fffffffd", hi_o, lo_o); end
      cyc();
      @(negedge clk);
      vectors++; if (whilo_o !== 1'b0 || hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_after: got whilo=%b hi=%h lo=%h want 0/ffffffff/fffffffd", whilo_o, hi_o, lo_o); end
   endtask

   task automatic test_unsigned();
      int pulses;
      cyc();
      aluop_i = DIVU_OP; reg1_i = 32'd100; reg2_i = 32'd7;
      @(negedge clk);
      vectors++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL udiv_accept: got stall=%b want 1", stallreq_o); end
      cyc();
      aluop_i = NOP_OP;
      @(negedge clk);
      vectors++; if (signed_div_o !== 1'b0 || div_start_o !== 1'b1 || div_opdata1_o !== 32'd100 || div_opdata2_o !== 32'd7) begin errors++; $display("FAIL udiv_busy: got signed=%b start=%b ops=%0d/%0d want 0/1/100/7", signed_div_o, div_start_o, div_opdata1_o, div_opdata2_o); end
      cyc();
      div_ready_i = 1'b1; div_result_i = {32'd2, 32'd14};
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         div_ready_i = 1'b0; div_result_i = 64'd0;
         @(negedge clk);
         if (whilo_o === 1'b1) pulses++;
      end
      vectors++; if (pulses !== 1) begin errors++; $display("FAIL udiv_pulses: got %0d want 1", pulses); end
      vectors++; if (hi_o !== 32'd2 || lo_o !== 32'd14) begin errors++; $display("FAIL udiv_result: got %0d/%0d want 2/14", hi_o, lo_o); end
   endtask

   task automatic test_flush();
      int pulses;
      cyc();
      aluop_i = DIVU_OP; reg1_i = 32'd50; reg2_i = 32'd5;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         @(negedge clk);
         vectors++; if (stallreq_o !== 1'b1 || div_annul_o !== 1'b0) begin errors++; $display("FAIL flush_busy%0d: got stall=%b annul=%b want 1/0", i, stallreq_o, div_annul_o); end
      end
      cyc();
      flush_i = 1'b1;
      @(negedge clk);
      vectors++; if (div_annul_o !== 1'b1 || whilo_o !== 1'b0) begin errors++; $display("FAIL flush_annul: got annul=%b whilo=%b want 1/0", div_annul_o, whilo_o); end
      cyc();
      flush_i = 1'b0; aluop_i = NOP_OP;
      @(negedge clk);
      vectors++; if (div_start_o !== 1'b0 || stallreq_o !== 1'b0 || div_annul_o !== 1'b0) begin errors++; $display("FAIL flush_idle: got start=%b stall=%b annul=%b want 000", div_start_o, stallreq_o, div_annul_o); end
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         div_ready_i = (i == 1);
         div_result_i = 64'h0000_0009_0000_0008;
         @(negedge clk);
         if (whilo_o === 1'b1) pulses++;
      end
      div_ready_i = 1'b0;
      vectors++; if (pulses !== 0) begin errors++; $display("FAIL flush_nowrite: got %0d pulses want 0", pulses); end
      vectors++; if (hi_o !== 32'd2 || lo_o !== 32'd14) begin errors++; $display("FAIL flush_hilo: got %0d/%0d want 2/14", hi_o, lo_o); end
   endtask

   task automatic test_flush_ready();
      int pulses;
      cyc();
      aluop_i = DIV_OP; reg1_i = 32'd77; reg2_i = 32'd8;
      cyc();
      cyc();
      flush_i = 1'b1; div_ready_i = 1'b1; div_result_i = {32'd5, 32'd9};
      @(negedge clk);
      vectors++; if (div_annul_o !== 1'b1) begin errors++; $display("FAIL fr_annul: got %b want 1", div_annul_o); end
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         flush_i = 1'b0; div_ready_i = 1'b0; aluop_i = NOP_OP;
         @(negedge clk);
         if (whilo_o === 1'b1) pulses++;
      end
      vectors++; if (pulses !== 0 || div_start_o !== 1'b0) begin errors++; $display("FAIL fr_nowrite: got pulses=%0d start=%b want 0/0", pulses, div_start_o); end
      vectors++; if (hi_o !== 32'd2 || lo_o !== 32'd14) begin errors++; $display("FAIL fr_nocapture: got %0d/%0d want 2/14", hi_o, lo_o); end
   endtask

   task automatic test_drain_flush();
      cyc();
      aluop_i = DIVU_OP; reg1_i = 32'd9; reg2_i = 32'd4;
      cyc();
      aluop_i = NOP_OP; div_ready_i = 1'b1; div_result_i = {32'd1, 32'd2};
      cyc();
      div_ready_i = 1'b0; flush_i = 1'b1;
      @(negedge clk);
      vectors++; if (whilo_o !== 1'b0 || stallreq_o !== 1'b0) begin errors++; $display("FAIL dflush_suppress: got whilo=%b stall=%b want 0/0", whilo_o, stallreq_o); end
      vectors++; if (hi_o !== 32'd1 || lo_o !== 32'd2) begin errors++; $display("FAIL dflush_capture: got %0d/%0d want 1/2", hi_o, lo_o); end
      cyc();
      flush_i = 1'b0;
      @(negedge clk);
      vectors++; if (whilo_o !== 1'b0 || div_start_o !== 1'b0) begin errors++; $display("FAIL dflush_idle: got whilo=%b start=%b want 0/0", whilo_o, div_start_o); end
   endtask

   task automatic test_back_to_back();
      cyc();
      aluop_i = DIVU_OP; reg1_i = 32'd10; reg2_i = 32'd3;
      @(negedge clk);
      vectors++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL b2b_accept1: got %b want 1", stallreq_o); end
      cyc();
      div_ready_i = 1'b1; div_result_i = {32'd1, 32'd3};
      @(negedge clk);
      vectors++; if (div_start_o !== 1'b1) begin errors++; $display("FAIL b2b_start1: got %b want 1", div_start_o); end
      cyc();
      div_ready_i = 1'b0; reg1_i = 32'd20; reg2_i = 32'd6;
      @(negedge clk);
      vectors++; if (whilo_o !== 1'b1 || hi_o !== 32'd1 || lo_o !== 32'd3 || div_start_o !== 1'b0 || stallreq_o !== 1'b0) begin errors++; $display("FAIL b2b_write1: got whilo=%b hi=%0d lo=%0d start=%b stall=%b want 1/1/3/0/0", whilo_o, hi_o, lo_o, div_start_o, stallreq_o); end
      cyc();
      @(negedge clk);
      vectors++; if (div_start_o !== 1'b0 || stallreq_o !== 1'b1 || div_opdata1_o !== 32'd10 || whilo_o !== 1'b0) begin errors++; $display("FAIL b2b_gap: got start=%b stall=%b op1=%0d whilo=%b want 0/1/10/0", div_start_o, stallreq_o, div_opdata1_o, whilo_o); end
      cyc();
      aluop_i = NOP_OP;
      @(negedge clk);
      vectors++; if (div_start_o !== 1'b1 || div_opdata1_o !== 32'd20 || div_opdata2_o !== 32'd6) begin errors++; $display("FAIL b2b_start2: got start=%b ops=%0d/%0d want 1/20/6", div_start_o, div_opdata1_o, div_opdata2_o); end
      cyc();
      div_ready_i = 1'b1; div_result_i = {32'd2, 32'd3};
      cyc();
      div_ready_i = 1'b0;
      @(negedge clk);
      vectors++; if (whilo_o !== 1'b1 || hi_o !== 32'd2 || lo_o !== 32'd3) begin errors++; $display("FAIL b2b_write2: got whilo=%b hi=%0d lo=%0d want 1/2/3", whilo_o, hi_o, lo_o); end
      cyc();
      @(negedge clk);
      vectors++; if (whilo_o !== 1'b0) begin errors++; $display("FAIL b2b_end: got whilo=%b want 0", whilo_o); end
   endtask

   task automatic test_async_reset();
      int pulses;
      cyc();
      aluop_i = DIV_OP; reg1_i = 32'h0000_1234; reg2_i = 32'h0000_0056;
      cyc();
      aluop_i = NOP_OP;
      cyc();
      @(negedge clk);
      vectors++; if (div_start_o !== 1'b1 || stallreq_o !== 1'b1) begin errors++; $display("FAIL ar_busy: got start=%b stall=%b want 1/1", div_start_o, stallreq_o); end
      #2;
      rst = 1'b0;
      #1;
      vectors++; if (div_start_o !== 1'b0 || signed_div_o !== 1'b0 || div_opdata1_o !== 32'd0 || div_opdata2_o !== 32'd0) begin errors++; $display("FAIL ar_regs: got start=%b signed=%b ops=%h/%h want 0/0/0/0", div_start_o, signed_div_o, div_opdata1_o, div_opdata2_o); end
      vectors++; if (hi_o !== 32'd0 || lo_o !== 32'd0 || stallreq_o !== 1'b0) begin errors++; $display("FAIL ar_hilo: got hi=%h lo=%h stall=%b want 0/0/0", hi_o, lo_o, stallreq_o); end
      @(negedge clk);
      #2;
      rst = 1'b1;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         div_ready_i = (i == 0);
         div_result_i = 64'h0000_0003_0000_0004;
         @(negedge clk);
         if (whilo_o === 1'b1) pulses++;
      end
      div_ready_i = 1'b0;
      vectors++; if (pulses !== 0 || div_start_o !== 1'b0 || hi_o !== 32'd0) begin errors++; $display("FAIL ar_release: got pulses=%0d start=%b hi=%h want 0/0/0", pulses, div_start_o, hi_o); end
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      test_reset();
      test_signed();
      test_unsigned();
      test_flush();
      test_flush_ready();
      test_drain_flush();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL declare parameter DIV_OP, default 8'b00011010, meaning the aluop code for a signed divide.
REQ-002 SHALL declare parameter DIVU_OP, default 8'b00011011, meaning the aluop code for an unsigned divide.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low (0 = reset asserted).
REQ-005 aluop_i  in  8  EX-stage operation code.
REQ-006 reg1_i  in  32  dividend from EX.
REQ-007 reg2_i  in  32  divisor from EX.
REQ-008 flush_i  in  1  pipeline flush; kills the divide in progress.
REQ-009 div_ready_i  in  1  divider result-ready flag.
REQ-010 div_result_i  in  64  divider result: remainder in [63:32], quotient in [31:0].
REQ-011 div_start_o  out  1  registered start request to the divider.
REQ-012 div_annul_o  out  1  abort request to the divider.
REQ-013 signed_div_o  out  1  registered signed/unsigned select.
REQ-014 div_opdata1_o  out  32  registered dividend, held stable for the whole operation.
REQ-015 div_opdata2_o  out  32  registered divisor, held stable for the whole operation.
REQ-016 stallreq_o  out  1  pipeline stall request.
REQ-017 whilo_o  out  1  HI/LO write enable, one-cycle pulse.
REQ-018 hi_o  out  32  remainder to write into HI.
REQ-019 lo_o  out  32  quotient to write into LO.

Function
REQ-020 The block SHALL implement a three-state FSM: IDLE, BUSY and DRAIN.
REQ-021 A request SHALL be defined as req = (aluop_i==DIV_OP or aluop_i==DIVU_OP) and flush_i==0.
REQ-022 IDLE:
- stallreq_o SHALL equal req (combinational).
- On req: latch reg1_i into div_opdata1_o and reg2_i into div_opdata2_o; set signed_div_o <= (aluop_i==DIV_OP); set div_start_o <= 1; next state BUSY.
- Without req: outputs hold; state stays IDLE.
REQ-023 BUSY:
- stallreq_o SHALL be 1.
- div_start_o, signed_div_o and both operand outputs SHALL hold unchanged.
REQ-024 BUSY with flush_i=1:
- div_annul_o = 1 in that cycle (combinational).
- div_start_o <= 0; next state IDLE; no HI/LO write.
- flush_i takes priority over a simultaneous div_ready_i.
REQ-025 BUSY with div_ready_i=1 and flush_i=0:
- hi_o <= div_result_i[63:32]; lo_o <= div_result_i[31:0].
- div_start_o <= 0; next state DRAIN.
REQ-026 DRAIN:
- stallreq_o = 0.
- whilo_o = ~flush_i (combinational), so a flush in DRAIN suppresses the write.
- aluop_i is ignored; next state IDLE unconditionally.
- The one-cycle start=0 gap lets the divider return to its free state.
REQ-027 div_annul_o SHALL be 0 outside BUSY, and whilo_o SHALL be 0 outside DRAIN.
REQ-028 hi_o and lo_o SHALL hold their last captured value until the next capture.
REQ-029 Divide-by-zero SHALL need no special handling here: the divider's result is captured unchanged.
REQ-030 Latency from the cycle req is accepted to the whilo_o pulse SHALL be (divider ready latency) + 2 cycles.
REQ-031 Back-to-back divides SHALL be accepted no earlier than the IDLE cycle after DRAIN.

Reset
REQ-032 While rst=0, regardless of clk:
- state = IDLE;
- div_start_o = 0, signed_div_o = 0;
- div_opdata1_o, div_opdata2_o, hi_o, lo_o = 0;
- combinational outputs stallreq_o, div_annul_o and whilo_o evaluate to 0 unless req is present.
REQ-033 Reset asserted mid-operation (BUSY or DRAIN) SHALL abandon the operation with no whilo_o pulse after release.

Verification
REQ-034 Signed divide: aluop=DIV_OP, reg1=0xFFFFFFF9 (-7), reg2=2; divider model returns {0xFFFFFFFF, 0xFFFFFFFD} -> start held high through BUSY, stallreq high until ready, then one-cycle whilo with hi=0xFFFFFFFF, lo=0xFFFFFFFD.
REQ-035 Unsigned divide: DIVU_OP, 100/7 -> signed_div_o=0, hi=2, lo=14, exactly one whilo pulse.
REQ-036 Flush at BUSY cycle 5 -> div_annul_o=1 for that cycle, start drops next edge, state IDLE, no whilo, hi/lo unchanged.
REQ-037 flush_i and div_ready_i asserted in the same BUSY cycle -> annul asserted, no capture, no whilo.
REQ-038 Back-to-back DIVU (10/3 then 20/6) -> two whilo pulses with hi/lo {1,3} then {2,3}, at least one start-low cycle between operations.
REQ-039 rst driven low asynchronously mid-BUSY -> all registered outputs 0 immediately; after release with no request, no whilo pulse appears.
